// File: rtl/conv3d_compute.sv
// Direct 3D convolution engine: one MAC per weight/ifm word pair, result written per output pixel.
// Latency: 5 cycles per MAC (read wt, wait, read ifm, wait, MAC) plus 1 WRITE cycle per output with no stalls.
// Backpressure: rd_req_ready / wr_ready stall the FSM in place; one read outstanding, addresses held stable.
module conv3d_compute #(
  parameter int IFM_DIM   = 28,
  parameter int IFM_DEPTH = 2,
  parameter int WT_DIM    = 5,
  parameter int OFM_DIM   = 24,
  parameter int OFM_DEPTH = 2,
  parameter int AWIDTH    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] ifm_base,
  input  logic [AWIDTH-1:0] wt_base,
  input  logic [AWIDTH-1:0] ofm_base,
  output logic              idle,
  output logic              done,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [AWIDTH-1:0] rd_req_addr,
  input  logic              rd_resp_valid,
  input  logic [31:0]       rd_resp_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [31:0]       wr_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WT,
    WAIT_WT,
    RD_IFM,
    WAIT_IFM,
    MAC,
    WRITE,
    DONE
  } state_t;

  // Address strides and loop limits, all at address width
  localparam logic [AWIDTH-1:0] ONE      = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] WT_PLANE = AWIDTH'(WT_DIM * WT_DIM);
  localparam logic [AWIDTH-1:0] WT_FILT  = AWIDTH'(IFM_DEPTH * WT_DIM * WT_DIM);
  localparam logic [AWIDTH-1:0] IFM_PLANE = AWIDTH'(IFM_DIM * IFM_DIM);
  localparam logic [AWIDTH-1:0] OFM_PLANE = AWIDTH'(OFM_DIM * OFM_DIM);
  localparam logic [AWIDTH-1:0] IFM_ROW  = AWIDTH'(IFM_DIM);
  localparam logic [AWIDTH-1:0] OFM_ROW  = AWIDTH'(OFM_DIM);
  localparam logic [AWIDTH-1:0] WT_ROW   = AWIDTH'(WT_DIM);
  localparam logic [AWIDTH-1:0] N_MAX    = AWIDTH'(WT_DIM - 1);
  localparam logic [AWIDTH-1:0] D_MAX    = AWIDTH'(IFM_DEPTH - 1);
  localparam logic [AWIDTH-1:0] J_MAX    = AWIDTH'(OFM_DIM - 1);
  localparam logic [AWIDTH-1:0] F_MAX    = AWIDTH'(OFM_DEPTH - 1);

  state_t state;
  state_t next_state;

  // Loop counters: f (output channel), i/j (output pixel), d/m/n (reduction)
  logic [AWIDTH-1:0] cnt_f, cnt_i, cnt_j, cnt_d, cnt_m, cnt_n;

  // Job bases captured on an accepted start so input changes mid-job are harmless
  logic [AWIDTH-1:0] ifm_base_q, wt_base_q, ofm_base_q;

  logic signed [31:0] wt_q;
  logic signed [31:0] ifm_q;
  logic signed [31:0] acc;
  logic signed [31:0] prod;

  logic [AWIDTH-1:0] wt_addr;
  logic [AWIDTH-1:0] ifm_addr;
  logic [AWIDTH-1:0] ofm_addr;

  logic last_red;
  logic last_pix;

  // Address generation and end-of-loop detection from the registered counters
  always_comb begin
    wt_addr  = wt_base_q + cnt_f * WT_FILT + cnt_d * WT_PLANE + cnt_m * WT_ROW + cnt_n;
    ifm_addr = ifm_base_q + cnt_d * IFM_PLANE + (cnt_i + cnt_m) * IFM_ROW + (cnt_j + cnt_n);
    ofm_addr = ofm_base_q + cnt_f * OFM_PLANE + cnt_i * OFM_ROW + cnt_j;
    last_red = (cnt_d == D_MAX) && (cnt_m == N_MAX) && (cnt_n == N_MAX);
    last_pix = (cnt_f == F_MAX) && (cnt_i == J_MAX) && (cnt_j == J_MAX);
    // Low 32 bits of the signed product; wraps like the accumulator
    prod     = ifm_q * wt_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; rd_resp_valid only matters in the two WAIT states
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start)         next_state = RD_WT;
      RD_WT:    if (rd_req_ready)  next_state = WAIT_WT;
      WAIT_WT:  if (rd_resp_valid) next_state = RD_IFM;
      RD_IFM:   if (rd_req_ready)  next_state = WAIT_IFM;
      WAIT_IFM: if (rd_resp_valid) next_state = MAC;
      MAC:      next_state = last_red ? WRITE : RD_WT;
      WRITE:    if (wr_ready)      next_state = last_pix ? DONE : RD_WT;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Moore outputs; address/data come from registers that only move on handshakes
  always_comb begin
    idle         = (state == IDLE);
    done         = (state == DONE);
    rd_req_valid = (state == RD_WT) || (state == RD_IFM);
    wr_valid     = (state == WRITE);
    rd_req_addr  = (state == RD_IFM) ? ifm_addr : wt_addr;
    wr_addr      = ofm_addr;
    wr_data      = acc;
  end

  // Capture job bases on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      ifm_base_q <= '0;
      wt_base_q  <= '0;
      ofm_base_q <= '0;
    end else if (state == IDLE && start) begin
      ifm_base_q <= ifm_base;
      wt_base_q  <= wt_base;
      ofm_base_q <= ofm_base;
    end
  end

  // Operand latches, loaded only when the matching response arrives in its WAIT state
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_q  <= '0;
      ifm_q <= '0;
    end else begin
      if (state == WAIT_WT && rd_resp_valid) begin
        wt_q <= rd_resp_data;
      end
      if (state == WAIT_IFM && rd_resp_valid) begin
        ifm_q <= rd_resp_data;
      end
    end
  end

  // Accumulator: cleared at job start and after each accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      case (state)
        IDLE:    if (start) acc <= '0;
        MAC:     acc <= acc + prod;
        WRITE:   if (wr_ready) acc <= '0;
        default: acc <= acc;
      endcase
    end
  end

  // Reduction counters (d,m,n) step per MAC and rewind after each written pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_d <= '0;
      cnt_m <= '0;
      cnt_n <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt_d <= '0;
            cnt_m <= '0;
            cnt_n <= '0;
          end
        end
        MAC: begin
          if (!last_red) begin
            if (cnt_n != N_MAX) begin
              cnt_n <= cnt_n + ONE;
            end else begin
              cnt_n <= '0;
              if (cnt_m != N_MAX) begin
                cnt_m <= cnt_m + ONE;
              end else begin
                cnt_m <= '0;
                cnt_d <= cnt_d + ONE;
              end
            end
          end
        end
        WRITE: begin
          if (wr_ready) begin
            cnt_d <= '0;
            cnt_m <= '0;
            cnt_n <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output-pixel counters (f,i,j) step once per accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_f <= '0;
      cnt_i <= '0;
      cnt_j <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt_f <= '0;
        cnt_i <= '0;
        cnt_j <= '0;
      end else if (state == WRITE && wr_ready) begin
        if (cnt_j != J_MAX) begin
          cnt_j <= cnt_j + ONE;
        end else begin
          cnt_j <= '0;
          if (cnt_i != J_MAX) begin
            cnt_i <= cnt_i + ONE;
          end else begin
            cnt_i <= '0;
            cnt_f <= (cnt_f == F_MAX) ? '0 : cnt_f + ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3d_compute.sv
// Bench for conv3d_compute: a small instance (3x3x1 ifm, 2x2 kernel) and a medium one (5x5x2, 3x3, 2 filters)
// share one memory model; sel picks which instance a job targets. Expected reads/writes come from
// a nested-loop convolution over the memory array.
module tb_conv3d_compute;

  localparam int A_ID = 3, A_IDEP = 1, A_WD = 2, A_OD = 2, A_ODEP = 1;
  localparam int B_ID = 5, B_IDEP = 2, B_WD = 3, B_OD = 3, B_ODEP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, sel;
  logic        rd_req_ready, rd_resp_valid, wr_ready;
  logic [31:0] rd_resp_data, ifm_base, wt_base, ofm_base;

  logic        a_idle, a_done, a_rrv, a_wv, b_idle, b_done, b_rrv, b_wv;
  logic [31:0] a_raddr, a_waddr, a_wdata, b_raddr, b_waddr, b_wdata;

  logic        o_idle, o_done, o_rrv, o_wv;
  logic [31:0] o_raddr, o_waddr, o_wdata;

  assign o_idle  = sel ? b_idle  : a_idle;
  assign o_done  = sel ? b_done  : a_done;
  assign o_rrv   = sel ? b_rrv   : a_rrv;
  assign o_wv    = sel ? b_wv    : a_wv;
  assign o_raddr = sel ? b_raddr : a_raddr;
  assign o_waddr = sel ? b_waddr : a_waddr;
  assign o_wdata = sel ? b_wdata : a_wdata;

  conv3d_compute #(.IFM_DIM(A_ID), .IFM_DEPTH(A_IDEP), .WT_DIM(A_WD), .OFM_DIM(A_OD),
                   .OFM_DEPTH(A_ODEP), .AWIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .ifm_base(ifm_base), .wt_base(wt_base), .ofm_base(ofm_base),
    .idle(a_idle), .done(a_done),
    .rd_req_valid(a_rrv), .rd_req_ready(rd_req_ready), .rd_req_addr(a_raddr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_valid(a_wv), .wr_ready(wr_ready), .wr_addr(a_waddr), .wr_data(a_wdata));

  conv3d_compute #(.IFM_DIM(B_ID), .IFM_DEPTH(B_IDEP), .WT_DIM(B_WD), .OFM_DIM(B_OD),
                   .OFM_DEPTH(B_ODEP), .AWIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .ifm_base(ifm_base), .wt_base(wt_base), .ofm_base(ofm_base),
    .idle(b_idle), .done(b_done),
    .rd_req_valid(b_rrv), .rd_req_ready(rd_req_ready), .rd_req_addr(b_raddr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_valid(b_wv), .wr_ready(wr_ready), .wr_addr(b_waddr), .wr_data(b_wdata));

  int mem [0:4095];
  int c_id, c_idep, c_wd, c_od, c_odep;
  int total = 0;
  int passed = 0;
  int lat_k;

  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
  logic [31:0] got_rd[$], got_wa[$], got_wd[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
  endtask

  task automatic set_cfg(input logic s);
    sel = s;
    if (!s) begin
      c_id = A_ID; c_idep = A_IDEP; c_wd = A_WD; c_od = A_OD; c_odep = A_ODEP;
      ifm_base = 32'd100; wt_base = 32'd200; ofm_base = 32'd300;
    end else begin
      c_id = B_ID; c_idep = B_IDEP; c_wd = B_WD; c_od = B_OD; c_odep = B_ODEP;
      ifm_base = 32'd1000; wt_base = 32'd2000; ofm_base = 32'd3000;
    end
  endtask

  // Reference convolution: expected read address stream, write addresses and sums
  function automatic void build_model();
    int acc, wa, ia;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    for (int f = 0; f < c_odep; f++)
      for (int i = 0; i < c_od; i++)
        for (int j = 0; j < c_od; j++) begin
          acc = 0;
          for (int d = 0; d < c_idep; d++)
            for (int m = 0; m < c_wd; m++)
              for (int n = 0; n < c_wd; n++) begin
                wa = int'(wt_base) + f * c_idep * c_wd * c_wd + d * c_wd * c_wd + m * c_wd + n;
                ia = int'(ifm_base) + d * c_id * c_id + (i + m) * c_id + (j + n);
                exp_rd.push_back(wa);
                exp_rd.push_back(ia);
                acc += mem[ia] * mem[wa];
              end
          exp_wa.push_back(int'(ofm_base) + f * c_od * c_od + i * c_od + j);
          exp_wd.push_back(acc);
        end
  endfunction

  // Drive one job cycle by cycle; inputs and sampling on the falling edge
  task automatic run_job(input int rdy_pct, input int max_dly, input bit spur,
                         input bit abort_on3, input int poke_at, input bit chk_lat);
    bit pend = 0, fin = 0, in_mac, mac_next = 0, aborted = 0;
    bit pv_r = 0, pr_r = 0, pv_w = 0, pr_w = 0;
    logic [31:0] pa_r = 0, pwa = 0, pwd = 0;
    logic [31:0] sv_ifm = ifm_base, sv_wt = wt_base, sv_ofm = ofm_base;
    int pidx = 0, dly = 0, ndone = 0, ovl = 0, stab = 0, resp_cnt = 0, k = 0, bad;
    got_rd.delete(); got_wa.delete(); got_wd.delete();
    lat_k = -1;
    @(negedge clk);
    rd_resp_valid = 0;
    start_a = !sel; start_b = sel;
    while (!fin && k < 40000) begin
      @(negedge clk);
      k++;
      start_a = 0; start_b = 0;
      in_mac = mac_next; mac_next = 0;
      if (k == poke_at) begin
        ifm_base = sv_ifm + 32'd7; wt_base = sv_wt + 32'd3; ofm_base = sv_ofm + 32'd11;
        start_a = !sel; start_b = sel;
      end
      rd_resp_valid = 0;
      rd_resp_data  = $urandom;
      if (pend) begin
        if (dly == 0) begin
          rd_resp_valid = 1; rd_resp_data = mem[pidx]; pend = 0;
          mac_next = (resp_cnt % 2 == 1);
          resp_cnt++;
        end else dly--;
      end else if (spur && $urandom_range(0, 3) == 0) rd_resp_valid = 1;
      if (abort_on3 && in_mac && got_wa.size() == 2) begin
        rst = 1; rd_req_ready = 0; wr_ready = 0; rd_resp_valid = 0;
        @(negedge clk);
        rst = 0;
        chk("abort_idle", 32'(o_idle), 32'd1);
        chk("abort_rd_valid", 32'(o_rrv), 32'd0);
        chk("abort_wr_valid", 32'(o_wv), 32'd0);
        bad = 0; rd_req_ready = 1; wr_ready = 1;
        for (int t = 0; t < 20; t++) begin
          rd_resp_valid = 1; rd_resp_data = $urandom;
          @(negedge clk);
          if (o_rrv || o_wv || !o_idle || o_done) bad++;
        end
        rd_resp_valid = 0;
        chk("abort_quiet", bad, 0);
        aborted = 1; fin = 1;
      end else begin
        if (pv_r && !pr_r && !(o_rrv && o_raddr == pa_r)) stab++;
        if (pv_w && !pr_w && !(o_wv && o_waddr == pwa && o_wdata == pwd)) stab++;
        rd_req_ready = ($urandom_range(0, 99) < rdy_pct);
        wr_ready     = ($urandom_range(0, 99) < rdy_pct);
        if (o_rrv && rd_req_ready) begin
          if (pend) ovl++;
          got_rd.push_back(o_raddr);
          pend = 1;
          pidx = (o_raddr < 4096) ? int'(o_raddr) : 0;
          dly  = $urandom_range(0, max_dly);
        end
        if (o_wv && wr_ready) begin
          got_wa.push_back(o_waddr);
          got_wd.push_back(o_wdata);
        end
        pv_r = o_rrv; pr_r = rd_req_ready; pa_r = o_raddr;
        pv_w = o_wv; pr_w = wr_ready; pwa = o_waddr; pwd = o_wdata;
        if (o_done) begin
          ndone++;
          if (ndone == 1) lat_k = k;
        end
        if (ndone > 0 && o_idle) fin = 1;
      end
    end
    ifm_base = sv_ifm; wt_base = sv_wt; ofm_base = sv_ofm;
    rd_req_ready = 0; wr_ready = 0; rd_resp_valid = 0;
    chk("job_finished", 32'(fin), 32'd1);
    if (abort_on3) chk("abort_hit", 32'(aborted), 32'd1);
    else begin
      chk("read_count", got_rd.size(), exp_rd.size());
      chk("write_count", got_wa.size(), exp_wa.size());
      for (int q = 0; q < exp_rd.size() && q < got_rd.size(); q++)
        if (got_rd[q] !== exp_rd[q]) chk($sformatf("rd_addr[%0d]", q), got_rd[q], exp_rd[q]);
      for (int q = 0; q < exp_wa.size() && q < got_wa.size(); q++) begin
        chk($sformatf("wr_addr[%0d]", q), got_wa[q], exp_wa[q]);
        chk($sformatf("wr_data[%0d]", q), got_wd[q], exp_wd[q]);
      end
      chk("done_pulses", ndone, 1);
      chk("one_outstanding", ovl, 0);
      chk("hold_stable", stab, 0);
      if (chk_lat)
        chk("latency", lat_k, c_odep * c_od * c_od * (c_idep * c_wd * c_wd * 5 + 1) + 1);
    end
  endtask

  task automatic fill_b_pattern();
    int idx;
    for (int x = 0; x < B_IDEP * B_ID * B_ID; x++) mem[1000 + x] = (x % 256) - 128;
    for (int f = 0; f < B_ODEP; f++)
      for (int d = 0; d < B_IDEP; d++)
        for (int m = 0; m < B_WD; m++)
          for (int n = 0; n < B_WD; n++) begin
            idx = f * B_IDEP * B_WD * B_WD + d * B_WD * B_WD + m * B_WD + n;
            mem[2000 + idx] = (n % 2 == 0) ? -(f + d + m + n) : (f + d + m + n);
          end
  endtask

  initial begin
    int e4 [4];
    rst = 1; start_a = 0; start_b = 0; sel = 0;
    rd_req_ready = 0; rd_resp_valid = 0; wr_ready = 0; rd_resp_data = 0;
    ifm_base = 0; wt_base = 0; ofm_base = 0;
    for (int x = 0; x < 4096; x++) mem[x] = 0;
    repeat (2) @(negedge clk);
    chk("rst_a_idle", 32'(a_idle), 32'd1);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_rd_valid", 32'(a_rrv), 32'd0);
    chk("rst_a_wr_valid", 32'(a_wv), 32'd0);
    chk("rst_a_acc", a_wdata, 32'd0);
    chk("rst_b_idle", 32'(b_idle), 32'd1);
    chk("rst_b_rd_valid", 32'(b_rrv), 32'd0);
    chk("rst_b_wr_valid", 32'(b_wv), 32'd0);
    rst = 0;
    @(negedge clk);

    // Small map 1..9, unit weights, no stalls: 12,16,24,28 and exact cycle count
    set_cfg(0);
    for (int x = 0; x < 9; x++) mem[100 + x] = x + 1;
    for (int x = 0; x < 4; x++) mem[200 + x] = 1;
    build_model();
    run_job(100, 0, 0, 0, 0, 1);
    e4 = '{12, 16, 24, 28};
    for (int q = 0; q < 4; q++)
      chk($sformatf("unit_wt_sum[%0d]", q), (q < got_wd.size()) ? got_wd[q] : 32'hDEADBEEF, e4[q]);

    // Signed operands: weights -1,1,-1,1 over -128..-120 give 2 everywhere
    for (int x = 0; x < 9; x++) mem[100 + x] = x - 128;
    mem[200] = -1; mem[201] = 1; mem[202] = -1; mem[203] = 1;
    build_model();
    run_job(60, 3, 1, 0, 0, 0);
    for (int q = 0; q < 4; q++)
      chk($sformatf("signed_sum[%0d]", q), (q < got_wd.size()) ? got_wd[q] : 32'hDEADBEEF, 32'd2);

    // Wrap: 0x7FFFFFFF * 2 keeps the low 32 bits
    for (int x = 0; x < 9; x++) mem[100 + x] = 32'h7FFFFFFF;
    mem[200] = 2; mem[201] = 0; mem[202] = 0; mem[203] = 0;
    build_model();
    run_job(100, 0, 0, 0, 0, 0);
    chk("wrap_product", (got_wd.size() > 0) ? got_wd[0] : 32'h0, 32'hFFFFFFFE);

    // Medium instance, index/sign pattern, no stalls then random stalls plus an ignored start
    set_cfg(1);
    fill_b_pattern();
    build_model();
    run_job(100, 0, 0, 0, 0, 1);
    run_job(60, 5, 1, 0, 50, 0);

    // Fully random operands with random handshakes
    for (int x = 0; x < B_IDEP * B_ID * B_ID; x++) mem[1000 + x] = $urandom;
    for (int x = 0; x < B_ODEP * B_IDEP * B_WD * B_WD; x++) mem[2000 + x] = $urandom;
    build_model();
    run_job(45, 5, 1, 0, 0, 0);

    // Reset during the third output's MAC, then a fresh run must be correct
    fill_b_pattern();
    build_model();
    run_job(70, 2, 1, 1, 0, 0);
    run_job(70, 4, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv3d_compute.md
CONV3D_COMPUTE -- requirements
Module: conv3d_compute

Interface
REQ-001 Parameters SHALL be: IFM_DIM 28, input map width/height; IFM_DEPTH 2, input channels; WT_DIM 5, kernel width/height; OFM_DIM 24, output width/height, equal to IFM_DIM-WT_DIM+1; OFM_DEPTH 2, output channels; AWIDTH 32, word-address width.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse, honoured only in IDLE.
REQ-005 ifm_base, wt_base, ofm_base  in  AWIDTH each  word base addresses, sampled on an accepted start.
REQ-006 idle  out  1  high in IDLE. done  out  1  one-cycle pulse after the last OFM write.
REQ-007 rd_req_valid out 1, rd_req_ready in 1, rd_req_addr out AWIDTH  memory read request channel.
REQ-008 rd_resp_valid in 1, rd_resp_data in 32  read response, in request order, signed two's complement.
REQ-009 wr_valid out 1, wr_ready in 1, wr_addr out AWIDTH, wr_data out 32  OFM write channel.

Function
REQ-010 The block SHALL compute ofm[f][i][j] = sum over d,m,n of ifm[d][i+m][j+n] * wt[f][d][m][n].
- Loop order, outer to inner: f, i, j, d, m, n.
REQ-011 Addresses SHALL be word indices:
- wt: wt_base + f*IFM_DEPTH*WT_DIM^2 + d*WT_DIM^2 + m*WT_DIM + n.
- ifm: ifm_base + d*IFM_DIM^2 + (i+m)*IFM_DIM + (j+n).
- ofm: ofm_base + f*OFM_DIM^2 + i*OFM_DIM + j.
REQ-012 Arithmetic SHALL use signed 32-bit operands and keep the low 32 bits of each product and of the accumulator, wrapping modulo 2^32 with no saturation.
REQ-013 The FSM SHALL have states IDLE, RD_WT, WAIT_WT, RD_IFM, WAIT_IFM, MAC, WRITE, DONE.
- IDLE->RD_WT on start: clear the accumulator and all loop counters.
- RD_WT->WAIT_WT when rd_req_valid&&rd_req_ready.
- WAIT_WT->RD_IFM on rd_resp_valid: latch the weight.
- RD_IFM->WAIT_IFM on handshake.
- WAIT_IFM->MAC on rd_resp_valid: latch the ifm word.
- MAC: acc += ifm*wt (one cycle). Then go to WRITE if d,m,n are all at their maximum; otherwise advance n/m/d and go to RD_WT.
- WRITE: hold wr_valid until wr_ready. On the handshake, clear acc and advance j/i/f. Go to DONE after the last pixel, otherwise to RD_WT.
- DONE: pulse done for one cycle, then go to IDLE.
REQ-014 rd_req_valid SHALL be high only in RD_WT and RD_IFM, and wr_valid only in WRITE. Address and data SHALL stay stable while valid is high and ready is low.
- Issue at most one outstanding read.
- Ignore rd_resp_valid outside the WAIT states.
REQ-015 wr_data SHALL equal the fully accumulated sum including the MAC of the final (d,m,n), i.e. the complete REQ-010 result.
REQ-016 start while not in IDLE SHALL be ignored.
REQ-017 Minimum latency per MAC with ready and response both in the same cycle SHALL be 5 cycles (RD_WT, WAIT_WT, RD_IFM, WAIT_IFM, MAC).
REQ-018 The write phase SHALL add one WRITE cycle per output when wr_ready=1.
REQ-019 Back-pressure on either channel SHALL stall without losing or duplicating any request or write.

Reset
REQ-020 On rst, the FSM SHALL go to IDLE and the following SHALL be 0: idle=1, done, rd_req_valid, wr_valid, counters, accumulator.
REQ-021 Reset mid-operation SHALL abort at once. No further request or write SHALL be issued, and a late rd_resp_valid SHALL be ignored.
REQ-022 The first accepted start after reset SHALL begin a fresh computation.

Verification
REQ-023 With IFM_DIM=3, IFM_DEPTH=1, WT_DIM=2, OFM_DIM=2, OFM_DEPTH=1, ifm=1..9 and all weights 1, a start SHALL produce 4 writes at ofm_base+0..3 with data 12, 16, 24, 28, followed by one done pulse.
REQ-024 Same setup with weights {-1,1,-1,1} and ifm=-128..-120 SHALL produce 2, 2, 2, 2, which checks signed multiply.
REQ-025 Defaults with the ifm pattern (index%256)-128 and the weight pattern ±(f+d+m+n), where the sign is negative for even n: all 1152 writes SHALL match a software conv3D model bit-exactly.
REQ-026 Random rd_req_ready, wr_ready and response delay (0-5 cycles) SHALL give results identical to REQ-025, with no extra or missing transactions.
REQ-027 Asserting rst for one cycle during the 3rd output's MAC SHALL give idle=1 on the next cycle with no further requests. A following start SHALL rerun correctly.
REQ-028 Operands 0x7FFFFFFF*2 SHALL wrap to 0xFFFFFFFE in the accumulator.
